// File: rtl/timer_pkg.sv
// Shared definitions for the reaction-timer controller: state codes, timer
// control codes, BCD time type and the LFSR seed.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        WAIT    = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4,
        FOUL    = 3'd5,
        TIMEOUT = 3'd6
    } state_e;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_CLR  = 2'b01;
    localparam logic [1:0] CTRL_STEP = 2'b10;

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] ms;
        logic [3:0] mms;
    } bcd_time_t;

    localparam bcd_time_t BCD_MAX = '{s: 4'd9, ms: 4'd9, mms: 4'd9};

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Valid BCD digits order the same way as the packed binary word.
    function automatic logic bcd_lt(input bcd_time_t a, input bcd_time_t b);
        return a < b;
    endfunction

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// Signal bundle between the reaction-timer controller (master) and the
// buttons / BCD stopwatch / display side (slave).
interface reaction_timer_ctrl_if;

    logic       btn_start;
    logic       btn_react;
    logic [3:0] sout;
    logic [3:0] msout;
    logic [3:0] mmsout;
    logic [1:0] ctrl;
    logic       led_go;
    logic       foul;
    logic [2:0] state;
    logic [3:0] best_s;
    logic [3:0] best_ms;
    logic [3:0] best_mms;
    logic       best_valid;
    logic       new_best;

    modport master (
        input  btn_start, btn_react, sout, msout, mmsout,
        output ctrl, led_go, foul, state,
        output best_s, best_ms, best_mms, best_valid, new_best
    );

    modport slave (
        output btn_start, btn_react, sout, msout, mmsout,
        input  ctrl, led_go, foul, state,
        input  best_s, best_ms, best_mms, best_valid, new_best
    );

endinterface

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1; never reaches zero.
module lfsr8
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= LFSR_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/reaction_timer_ctrl.sv
// Reaction-game sequencer: drives the BCD stopwatch control, runs a random
// get-ready delay, flags false starts / timeouts and keeps the best time.
module reaction_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV       = 1_000_000,
    parameter int MIN_WAIT_TICKS = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    reaction_timer_ctrl_if.master bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(MIN_WAIT_TICKS + 256);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e          state_q, state_d;
    logic            start_q, start_d;
    logic            react_q, react_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   delay_q, delay_d;
    bcd_time_t       best_q, best_d;
    logic            best_valid_q, best_valid_d;
    logic            new_best_q, new_best_d;
    logic            cmp_en_q, cmp_en_d;

    logic [7:0]      lfsr_val;
    logic            start_rise;
    logic            react_rise;
    logic            tick;
    logic            at_max;
    logic [1:0]      ctrl;
    bcd_time_t       cur;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_val)
    );

    assign cur = '{s: bus.sout, ms: bus.msout, mms: bus.mmsout};

    always_comb begin
        start_d    = bus.btn_start;
        react_d    = bus.btn_react;
        start_rise = bus.btn_start & ~start_q;
        react_rise = bus.btn_react & ~react_q;
        tick       = (presc_q == PRESC_LAST);
        at_max     = (cur == BCD_MAX);
    end

    always_comb begin
        state_d      = state_q;
        presc_d      = tick ? '0 : presc_q + PW'(1);
        delay_d      = delay_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        new_best_d   = 1'b0;
        cmp_en_d     = 1'b0;
        ctrl         = CTRL_HOLD;

        case (state_q)
            IDLE: begin
                if (start_rise) state_d = CLEAR;
            end
            CLEAR: begin
                ctrl    = CTRL_CLR;
                presc_d = '0;
                delay_d = DW'(MIN_WAIT_TICKS) + DW'(lfsr_val);
                state_d = WAIT;
            end
            WAIT: begin
                // A press before go is a false start even on the expiry tick.
                if (react_rise) begin
                    state_d = FOUL;
                end else if (tick) begin
                    if (delay_q == DW'(1)) begin
                        state_d = RUN;
                        presc_d = '0;
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end
            RUN: begin
                if (tick && !react_rise && !at_max) ctrl = CTRL_STEP;
                if (react_rise) begin
                    state_d  = DONE;
                    cmp_en_d = 1'b1;
                end else if (tick && at_max) begin
                    state_d = TIMEOUT;
                end
            end
            DONE: begin
                // Timer digits settle one clk after the last step, so compare here.
                if (cmp_en_q) begin
                    if (!best_valid_q || bcd_lt(cur, best_q)) begin
                        best_d       = cur;
                        best_valid_d = 1'b1;
                        new_best_d   = 1'b1;
                    end
                end else if (start_rise) begin
                    state_d = CLEAR;
                end
            end
            FOUL, TIMEOUT: begin
                if (start_rise) state_d = CLEAR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            react_q      <= 1'b0;
            presc_q      <= '0;
            delay_q      <= '0;
            best_q       <= BCD_MAX;
            best_valid_q <= 1'b0;
            new_best_q   <= 1'b0;
            cmp_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            react_q      <= react_d;
            presc_q      <= presc_d;
            delay_q      <= delay_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            new_best_q   <= new_best_d;
            cmp_en_q     <= cmp_en_d;
        end
    end

    assign bus.ctrl       = ctrl;
    assign bus.led_go     = (state_q == RUN);
    assign bus.foul       = (state_q == FOUL);
    assign bus.state      = state_q;
    assign bus.best_s     = best_q.s;
    assign bus.best_ms    = best_q.ms;
    assign bus.best_mms   = best_q.mms;
    assign bus.best_valid = best_valid_q;
    assign bus.new_best   = new_best_q;

endmodule

// File: doc/reaction_timer_ctrl.md
# reaction_timer_ctrl

Sequencing controller for the BCD stopwatch timer in the reaction-time game. Owns the timer's 2-bit control input (01 = clear, 10 = count one step, 00 = hold). Generates the count-step tick from the system clock, runs a pseudo-random "get ready" delay, and detects false starts and timeouts. Tracks the best (lowest) reaction time from the timer's digit outputs.

## Interface
- TICK_DIV, 1_000_000: clk cycles per count step (10 ms at 100 MHz, so digits read s / 0.1 s / 0.01 s)
- MIN_WAIT_TICKS, 100: minimum random-delay length, in ticks
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- btn_start  input  1  debounced, synchronised start button (level)
- btn_react  input  1  debounced, synchronised react button (level)
- sout  input  4  timer seconds digit (BCD)
- msout  input  4  timer tenths digit (BCD)
- mmsout  input  4  timer hundredths digit (BCD)
- ctrl  output  2  timer control: 01 clear, 10 step, 00 hold
- led_go  output  1  high while in RUN
- foul  output  1  high while in FOUL
- state  output  3  current FSM state code
- best_s, best_ms, best_mms  output  4 each  best time (BCD)
- best_valid  output  1  at least one completed run recorded
- new_best  output  1  one-cycle pulse when the best time updates

## Operation
- Edge detect:
  - start_rise = btn_start & ~start_q; react_rise = btn_react & ~react_q.
  - start_q and react_q are registered copies of the buttons; both reset to 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = (count == TICK_DIV-1).
  - Forced to 0 in CLEAR and on the WAIT->RUN transition.
- LFSR (lfsr8):
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Seed 8'hA5 at reset; advances every clk.
- ctrl (combinational from state):
  - 01 in CLEAR.
  - 10 in RUN when tick & ~react_rise & ~at_max.
  - 00 otherwise.
  - at_max = (sout,msout,mmsout == 9,9,9).
- States and codes (all transitions registered):
  - IDLE 0: start_rise -> CLEAR.
  - CLEAR 1: unconditional -> WAIT after one cycle. On that edge, load delay_cnt = MIN_WAIT_TICKS + lfsr.
  - WAIT 2:
    - react_rise -> FOUL. This has priority over delay expiry.
    - Otherwise, on tick: if delay_cnt == 1 -> RUN, else delay_cnt decrements.
  - RUN 3:
    - react_rise -> DONE. The step is suppressed that cycle.
    - Else tick & at_max -> TIMEOUT.
    - start_rise is ignored.
  - DONE 4:
    - First cycle in DONE: compare the timer digits with best as a 12-bit BCD magnitude compare.
    - If !best_valid or time < best: load best, set best_valid, pulse new_best.
    - Afterwards, start_rise -> CLEAR.
  - FOUL 5: start_rise -> CLEAR; best is not touched.
  - TIMEOUT 6: start_rise -> CLEAR; best is not touched; 9.99 stays on the timer outputs.
- Code 7 is unreachable and recovers to IDLE.
- btn_react is ignored in IDLE, CLEAR, DONE, FOUL and TIMEOUT.

## Timing
- Reset values:
  - state = IDLE, ctrl = 00, led_go = 0, foul = 0.
  - best = 9,9,9, best_valid = 0, new_best = 0.
  - Prescaler and delay_cnt = 0.
- The timer registers ctrl, so its digits reflect a step one clk after ctrl = 10.
  - The DONE compare happens on the second clk after react_rise; the digits are stable by then.
- react_rise at cycle n in RUN: ctrl = 00 at n, state = DONE at n+1, new_best high during n+2 only.
- First step after go is exactly TICK_DIV cycles after RUN is entered.
- Delay range: MIN_WAIT_TICKS .. MIN_WAIT_TICKS+255 ticks.
  - The LFSR never yields 0, so the effective minimum is MIN_WAIT_TICKS+1.
- An asynchronous rst mid-run immediately drives ctrl = 00 and clears best.
  - The timer digits are not cleared until the next CLEAR.

## Structure
- Shared package timer_pkg holds:
  - the state encodings (IDLE..TIMEOUT);
  - the ctrl codes CTRL_HOLD = 2'b00, CTRL_CLR = 2'b01, CTRL_STEP = 2'b10;
  - the BCD max constant 9,9,9;
  - the LFSR seed.
- Sub-module lfsr8 (clk, rst, q[7:0]).
- Prescaler, FSM and best-time register live in reaction_timer_ctrl.

## Test plan
All scenarios use TICK_DIV = 4 and MIN_WAIT_TICKS = 2, with the real timer instantiated alongside.
- Reset then idle: ctrl stays 00, state 0, best = 9,9,9, best_valid = 0, with no button activity for 100 cycles.
- Normal run:
  - start pulse -> exactly one ctrl = 01 cycle -> WAIT.
  - After delay expiry, led_go = 1.
  - After 37 ticks, react pulse -> digits 0,3,7; DONE; new_best one cycle; best = 0,3,7.
- Slower second run (react after 50 ticks): best stays 0,3,7 and new_best stays 0. A following 20-tick run -> best = 0,2,0.
- React during WAIT: FOUL, foul = 1, ctrl never 10, best unchanged; start then recovers to CLEAR.
- No react: timer stops at 9,9,9, state = TIMEOUT, ctrl = 00 thereafter, no wrap past 9.99.
- Edge cases:
  - react_rise coincident with tick in RUN -> no step; recorded time equals the pre-tick value.
  - rst asserted mid-RUN -> ctrl = 00 in the same cycle, state = IDLE.
